bb_pi_loop_filter: RTL and testbench
====================================

# bb_pi_loop_filter

Second-order proportional-integral loop filter for bang-bang (early/late) phase detectors in the CDR/PLL datapath. It accepts a ternary up/down decision per enabled cycle and adds a runtime-programmable integral step to a fixed-point integrator. It outputs integrator plus proportional kick as a registered, signed control word for the NCO/DCO. A windowed lock detector and optional saturation make it the general-purpose replacement for the first-order up/down accumulator.

## Interface
- WIDTH, 24, integer bits of the output control word (signed)
- FW, 16, fractional bits carried internally; internal width IW = WIDTH+FW
- LOCK_WIN, 64, en-cycles per lock-evaluation window (power of two, >=2)
- LOCK_TH, 4, max |net decision count| per window that counts as locked
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- en  in  1  decision strobe; up/dn sampled only when high
- up  in  1  phase-early decision
- dn  in  1  phase-late decision
- ki  in  IW  unsigned integral gain, FW fractional bits
- kp  in  IW  unsigned proportional gain, FW fractional bits
- clr  in  1  synchronous integrator/lock clear without full reset
- out  out  WIDTH  signed control word, (integ + d·kp) >>> FW
- out_vld  out  1  one-cycle pulse, out updated this cycle
- lock  out  1  lock indicator, updated at window end

## Operation
- Decision d: up&~dn → +1; dn&~up → −1; up==dn → 0.
- On en edge: integ_n = integ + d·ki; integ <= integ_n; sum = integ_n + d·kp (IW+1 bits); out <= sum >>> FW reduced to WIDTH bits; out_vld <= 1.
- en low: integ, out, lock, counters hold; out_vld <= 0.
- Arithmetic two's complement throughout; ki/kp zero-extended before signed multiply-by-d (negation, no multiplier).
- Proportional term is not stored; it affects only the cycle's out.
- Lock detector: window counter wc (0..LOCK_WIN−1) and signed net counter (clog2(LOCK_WIN)+1 bits) advance on each en. On the en where wc==LOCK_WIN−1: lock <= (|net+d| <= LOCK_TH); net <= 0; wc <= 0. Otherwise net <= net+d, wc <= wc+1.
- Gain changes on ki/kp take effect on the next en; no internal gain register.
- Priority: rst > clr > en. clr: integ, net, wc, lock <= 0; out <= 0; out_vld <= 0.

## Timing
- Reset values: out=0, out_vld=0, lock=0, integ=0, net=0, wc=0.
- Latency: decision sampled at edge N appears on out/out_vld after edge N (one register stage).
- Back-to-back en every cycle supported; throughput one decision per clock.
- lock changes only in the cycle after a window-closing en; stable otherwise.
- rst or clr mid-window discards the partial window; next window starts at wc=0.

## Configuration
- BB_LF_SAT_EN defined: integ_n clamps to [−2^(IW−1), 2^(IW−1)−1]; sum clamps to the same range before the shift, so out is bounded to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Undefined: integ_n and sum wrap modulo 2^IW (sum's extra bit discarded); no comparators synthesised.

## Test plan
- Reset, ki=65536 (1.0), kp=262144 (4.0), en=1 with up=1 for 3 cycles then dn=1 for 1 cycle → out 5,6,7, then −2; out_vld high each cycle after en; integ ends at 2.0.
- up=dn=1 and up=dn=0 with en=1, integ at 3.0 → out=3 each cycle, integ unchanged; en=0 → out_vld=0, out holds.
- BB_LF_SAT_EN defined, ki=2^38, kp=0, up held → out clamps at 8388607 and stays; reverse with dn → first step down from clamp value (no wrap). Undefined → out wraps to negative after crossing 2^23.
- LOCK_WIN=8, LOCK_TH=2: 8 en cycles alternating up/dn → lock=1 after 8th; next 8 cycles all up (net=8) → lock=0 after 16th.
- Mid-run (integ=5.0, wc=3) assert clr one cycle → out=0, lock=0; next en with up, ki=1.0, kp=0 → out=1; window restarts at wc=0. Same with rst → identical.
- Change kp 4.0→0.0 between two up decisions with ki=1.0 → outs 5 then 2.

Source files
------------

// File: rtl/bb_pi_loop_filter.sv
// Second-order PI loop filter for bang-bang phase detectors, with windowed lock detect.
// Optional `BB_LF_SAT_EN: clamp integrator and output sum instead of wrapping.
module bb_pi_loop_filter #(
  parameter int WIDTH    = 24,
  parameter int FW       = 16,
  parameter int LOCK_WIN = 64,
  parameter int LOCK_TH  = 4,
  localparam int IW      = WIDTH + FW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             dn,
  input  logic [IW-1:0]    ki,
  input  logic [IW-1:0]    kp,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic             lock
);

  localparam int CW = $clog2(LOCK_WIN);
  localparam int NW = CW + 1;

  logic signed [IW-1:0]   integ, integ_n, sum;
  logic signed [IW+1:0]   dki, dkp, integ_w, sum_w;
  logic signed [1:0]      d;
  logic [CW-1:0]          wc;
  logic signed [NW-1:0]   net;
  logic signed [NW:0]     net_n;
  logic                   win_end, locked_n;
  logic                   unused_ok;

  always_comb begin
    d = 2'sd0;
    if (up && !dn)      d = 2'sd1;
    else if (dn && !up) d = -2'sd1;
  end

  // Gains are unsigned; d*gain is just select/negate on a zero-extended copy.
  always_comb begin
    dki = '0;
    dkp = '0;
    if (d == 2'sd1) begin
      dki = {2'b00, ki};
      dkp = {2'b00, kp};
    end else if (d == -2'sd1) begin
      dki = -{2'b00, ki};
      dkp = -{2'b00, kp};
    end
  end

  assign integ_w = {{2{integ[IW-1]}}, integ} + dki;
  assign sum_w   = {{2{integ_n[IW-1]}}, integ_n} + dkp;

`ifdef BB_LF_SAT_EN
  localparam logic signed [IW+1:0] SMAX = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [IW+1:0] SMIN = {3'b111, {(IW-1){1'b0}}};

  function automatic logic signed [IW-1:0] clamp(input logic signed [IW+1:0] v);
    if (v > SMAX)      clamp = SMAX[IW-1:0];
    else if (v < SMIN) clamp = SMIN[IW-1:0];
    else               clamp = v[IW-1:0];
  endfunction

  assign integ_n   = clamp(integ_w);
  assign sum       = clamp(sum_w);
  assign unused_ok = ^sum[FW-1:0];
`else
  assign integ_n   = integ_w[IW-1:0];
  assign sum       = sum_w[IW-1:0];
  assign unused_ok = ^{integ_w[IW+1:IW], sum_w[IW+1:IW], sum[FW-1:0]};
`endif

  // Net count is one bit wider so the window's final +/-LOCK_WIN cannot overflow.
  assign net_n    = {net[NW-1], net} + {{(NW-1){d[1]}}, d};
  assign win_end  = (wc == CW'(LOCK_WIN - 1));
  assign locked_n = (net_n <= LOCK_TH) && (net_n >= -LOCK_TH);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      integ   <= '0;
      out     <= '0;
      out_vld <= 1'b0;
      lock    <= 1'b0;
      net     <= '0;
      wc      <= '0;
    end else if (en) begin
      integ   <= integ_n;
      out     <= sum[IW-1:FW];
      out_vld <= 1'b1;
      if (win_end) begin
        lock <= locked_n;
        net  <= '0;
        wc   <= '0;
      end else begin
        net  <= net_n[NW-1:0];
        wc   <= wc + 1'b1;
      end
    end else begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bb_pi_loop_filter.sv
// Directed bench for bb_pi_loop_filter (LOCK_WIN=8, LOCK_TH=2); expectations hand-computed.
module tb_bb_pi_loop_filter;

  localparam int WIDTH = 24;
  localparam int FW    = 16;
  localparam int IW    = WIDTH + FW;
  localparam logic [IW-1:0] ONE = 40'd65536;

  logic clk = 1'b0;
  logic rst, en, up, dn, clr;
  logic [IW-1:0] ki, kp;
  logic [WIDTH-1:0] out;
  logic out_vld, lock;

  int n_chk  = 0;
  int n_pass = 0;

  bb_pi_loop_filter #(.WIDTH(WIDTH), .FW(FW), .LOCK_WIN(8), .LOCK_TH(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .dn(dn),
    .ki(ki), .kp(kp), .clr(clr),
    .out(out), .out_vld(out_vld), .lock(lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Apply one cycle of inputs; outputs are stable 1 time unit after the edge.
  task automatic cyc(input logic e, input logic u, input logic d);
    en = e; up = u; dn = d;
    @(posedge clk); #1;
    en = 1'b0; up = 1'b0; dn = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  function automatic longint so(input logic [WIDTH-1:0] v);
    return longint'($signed(v));
  endfunction

  // Build lock=1 with integ=3.0 mid-window, clear by rst or clr, then prove a fresh window.
  task automatic clear_test(input bit use_rst, input string nm);
    do_rst();
    ki = ONE; kp = '0;
    for (int i = 0; i < 8; i++) cyc(1, (i % 2) == 0, (i % 2) == 1);
    chk({nm, "_pre_lock"}, lock, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    chk({nm, "_pre_out"}, so(out), 3);
    if (use_rst) do_rst(); else do_clr();
    chk({nm, "_out0"}, so(out), 0);
    chk({nm, "_lock0"}, lock, 0);
    chk({nm, "_vld0"}, out_vld, 0);
    cyc(1, 1, 0);
    chk({nm, "_first"}, so(out), 1);
    for (int i = 1; i < 7; i++) cyc(1, (i % 2) == 0, (i % 2) == 1);
    chk({nm, "_win7"}, lock, 0);
    cyc(1, 0, 1);
    chk({nm, "_win8"}, lock, 1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; dn = 1'b0; clr = 1'b0;
    ki = '0; kp = '0;
    do_rst();
    chk("rst_out", so(out), 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_lock", lock, 0);

    // PI steps: ki=1.0, kp=4.0
    ki = ONE; kp = 40'd262144;
    cyc(1, 1, 0); chk("pi_up1", so(out), 5); chk("pi_vld1", out_vld, 1);
    cyc(1, 1, 0); chk("pi_up2", so(out), 6);
    cyc(1, 1, 0); chk("pi_up3", so(out), 7); chk("pi_vld3", out_vld, 1);
    cyc(1, 0, 1); chk("pi_dn", so(out), -2);
    cyc(1, 1, 0); chk("pi_to3", so(out), 7);

    // Zero decisions with integ=3.0
    cyc(1, 1, 1); chk("zero_both", so(out), 3); chk("zero_vld", out_vld, 1);
    cyc(1, 0, 0); chk("zero_none", so(out), 3);
    cyc(0, 1, 0); chk("idle_vld", out_vld, 0); chk("idle_out", so(out), 3);
    cyc(0, 0, 1); chk("idle_hold", so(out), 3);

    // Lock detector
    do_rst();
    ki = '0; kp = '0;
    for (int i = 0; i < 7; i++) cyc(1, (i % 2) == 0, (i % 2) == 1);
    chk("lock_7", lock, 0);
    cyc(1, 0, 1); chk("lock_8", lock, 1);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0);
    chk("lock_15", lock, 1);
    cyc(1, 1, 0); chk("lock_16", lock, 0);
    cyc(0, 0, 0); chk("lock_hold", lock, 0);

    clear_test(1'b0, "clr");
    clear_test(1'b1, "rst");

    // Proportional gain change between decisions
    do_clr();
    ki = ONE; kp = 40'd262144;
    cyc(1, 1, 0); chk("kp4", so(out), 5);
    kp = '0;
    cyc(1, 1, 0); chk("kp0", so(out), 2);

    // Large steps: clamp or wrap at 2^23
    do_clr();
    ki = 40'h40_0000_0000; kp = '0;
    cyc(1, 1, 0); chk("big1", so(out), 4194304);
`ifdef BB_LF_SAT_EN
    cyc(1, 1, 0); chk("sat_hi", so(out), 8388607);
    cyc(1, 1, 0); chk("sat_stay", so(out), 8388607);
    cyc(1, 0, 1); chk("sat_down", so(out), 4194303);
`else
    cyc(1, 1, 0); chk("wrap_hi", so(out), -8388608);
    cyc(1, 1, 0); chk("wrap_next", so(out), -4194304);
    cyc(1, 0, 1); chk("wrap_down", so(out), -8388608);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_chk);
    $fatal(1);
  end

endmodule
